// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq -- sequential AES InvSubBytes for the decrypt round loop.
// Accepts one 128-bit state over a valid/ready handshake, replaces every byte with
// its inverse S-box value, LANES 32-bit words per clock, and presents the result
// on out_data until downstream takes it.
// Optional feature macro: INV_SUB_MODE_EN -- adds the `mode` port and the forward
// S-box so the block can serve both encrypt (mode=0) and decrypt (mode=1).
module inv_sub_bytes_seq #(
   parameter int LANES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
`ifdef INV_SUB_MODE_EN
   input  logic         mode,
`endif
   output logic [127:0] out_data
);

   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
      $error("inv_sub_bytes_seq: LANES must be 1, 2 or 4 (got %0d)", LANES);
   end

   // Word 0 sits in the MSBs, so an ascending word range makes index == word number.
   typedef logic [0:3][31:0] words_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_state_e;

   // Counter value at which the final word group is being written.
   localparam logic [1:0] LAST_CNT = 2'(4 - LANES);
   localparam logic [1:0] CNT_STEP = 2'(LANES);

   // Inverse S-box, entry 0 in the MSBs (FIPS-197 Fig. 14).
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [31:0] inv_word(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = INV_SBOX[w[8*b +: 8]];
      end
      return r;
   endfunction

`ifdef INV_SUB_MODE_EN
   // Forward S-box, entry 0 in the MSBs (FIPS-197 Fig. 7).
   localparam logic [0:255][7:0] FWD_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [31:0] fwd_word(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = FWD_SBOX[w[8*b +: 8]];
      end
      return r;
   endfunction
`endif

   fsm_state_e   state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   words_t       work_q, work_d;
   words_t       work_run;
   logic [127:0] out_data_q, out_data_d;
   logic         out_valid_q, out_valid_d;
`ifdef INV_SUB_MODE_EN
   logic         mode_q, mode_d;
`endif

   // Acceptance depends on state alone: no combinational path from in_valid or out_ready.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // Substitute the LANES words addressed by the counter; the other words pass through.
   always_comb begin
      work_run = work_q;
      for (int l = 0; l < LANES; l++) begin
`ifdef INV_SUB_MODE_EN
         work_run[cnt_q + 2'(l)] = mode_q ? inv_word(work_q[cnt_q + 2'(l)])
                                          : fwd_word(work_q[cnt_q + 2'(l)]);
`else
         work_run[cnt_q + 2'(l)] = inv_word(work_q[cnt_q + 2'(l)]);
`endif
      end
   end

   // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE.
   always_comb begin
      // NOTE: every target gets its hold value first so no path through the case leaves one unassigned (which would infer a latch).
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
`ifdef INV_SUB_MODE_EN
      mode_d      = mode_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               cnt_d   = 2'd0;
               state_d = S_RUN;
`ifdef INV_SUB_MODE_EN
               mode_d  = mode;
`endif
            end
         end
         S_RUN: begin
            work_d = work_run;
            cnt_d  = cnt_q + CNT_STEP;
            if (cnt_q == LAST_CNT) begin
               out_data_d  = work_run;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; a reset discards any transaction.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         work_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef INV_SUB_MODE_EN
         mode_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef INV_SUB_MODE_EN
         mode_q      <= mode_d;
`endif
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq -- bench for inv_sub_bytes_seq with LANES = 1, 2 and 4 side by side.
// The reference S-boxes are derived from GF(2^8) inversion plus the AES affine map.
module tb_inv_sub_bytes_seq;

   localparam int NDUT     = 3;
   localparam int MAX_WAIT = 20;

   logic            clk;
   logic            rst_n;
   logic [NDUT-1:0] in_valid;
   logic [NDUT-1:0] in_ready;
   logic [NDUT-1:0] out_valid;
   logic [NDUT-1:0] out_ready;
`ifdef INV_SUB_MODE_EN
   logic [NDUT-1:0] mode;
`endif
   logic [127:0]    in_data  [NDUT];
   logic [127:0]    out_data [NDUT];

   int check_cnt = 0;
   int pass_cnt  = 0;

   logic [7:0] ref_sbox  [256];
   logic [7:0] ref_isbox [256];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
`ifdef INV_SUB_MODE_EN
         .mode      (mode[g]),
`endif
         .out_data  (out_data[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gf_mul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   task automatic build_ref();
      logic [7:0] b;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         b = gf_inv(8'(x));
         s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
         ref_sbox[x]  = s;
         ref_isbox[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_state(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int b = 0; b < 16; b++)
         r[8*b +: 8] = inv ? ref_isbox[d[8*b +: 8]] : ref_sbox[d[8*b +: 8]];
      return r;
   endfunction

   // ---------------- stimulus driver (observes, does not judge) ----------------
   task automatic do_txn(input int k, input logic [127:0] data, input bit noisy,
                         output logic [127:0] res, output int lat,
                         output bit busy_ok, output bit done_ok);
      res = '0;
      lat = 0;
      if (noisy) repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      in_valid[k] = 1'b1;
      in_data[k]  = data;
      @(negedge clk);
      busy_ok = (in_ready[k] === 1'b0);
      while (out_valid[k] !== 1'b1 && lat < MAX_WAIT) begin
         if (noisy) begin
            in_valid[k]  = 1'($urandom_range(0, 1));
            in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
            out_ready[k] = 1'($urandom_range(0, 1));
         end else begin
            in_valid[k]  = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      in_valid[k]  = 1'b0;
      in_data[k]   = data;
      res          = out_data[k];
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      done_ok = (out_valid[k] === 1'b0) && (in_ready[k] === 1'b1);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bit seen;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check_cnt++;
         if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_data[k] !== 128'h0)
            $display("FAIL reset_state[%0d]: got in_ready=%b out_valid=%b out_data=%h, want 1 0 0",
                     k, in_ready[k], out_valid[k], out_data[k]);
         else pass_cnt++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         in_valid[k] = 1'b1;
         in_data[k]  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
         @(negedge clk);
         in_valid[k] = 1'b0;
         @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check_cnt++;
         if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_data[k] !== 128'h0)
            $display("FAIL reset_mid_run[%0d]: got in_ready=%b out_valid=%b out_data=%h, want 1 0 0",
                     k, in_ready[k], out_valid[k], out_data[k]);
         else pass_cnt++;
         seen = 1'b0;
         out_ready[k] = 1'b1;
         repeat (8) begin
            @(negedge clk);
            if (out_valid[k] !== 1'b0) seen = 1'b1;
         end
         out_ready[k] = 1'b0;
         check_cnt++;
         if (seen !== 1'b0)
            $display("FAIL reset_discard[%0d]: got out_valid pulse=%b after reset, want 0", k, seen);
         else pass_cnt++;
      end
   endtask

   task automatic test_known_vector();
      logic [127:0] res;
      int lat;
      bit busy_ok, done_ok;
      do_txn(0, 128'h637C16ED_00000000_63636363_7C7C7C7C, 1'b0, res, lat, busy_ok, done_ok);
      check_cnt++;
      if (res !== 128'h0001FF53_52525252_00000000_01010101)
         $display("FAIL known_vector_data: got %h, want %h", res, 128'h0001FF53_52525252_00000000_01010101);
      else pass_cnt++;
      check_cnt++;
      if (lat !== 4) $display("FAIL known_vector_latency: got %0d, want 4", lat);
      else pass_cnt++;
      check_cnt++;
      if (busy_ok !== 1'b1 || done_ok !== 1'b1)
         $display("FAIL known_vector_handshake: got busy_ok=%b done_ok=%b, want 1 1", busy_ok, done_ok);
      else pass_cnt++;
   endtask

   task automatic test_lanes();
      logic [127:0] data, res, exp;
      int lat;
      bit busy_ok, done_ok;
      data = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
      exp  = ref_state(data, 1'b1);
      for (int k = 0; k < NDUT; k++) begin
         do_txn(k, data, 1'b0, res, lat, busy_ok, done_ok);
         check_cnt++;
         if (res !== exp) $display("FAIL lanes_data[L=%0d]: got %h, want %h", 1 << k, res, exp);
         else pass_cnt++;
         check_cnt++;
         if (lat !== (4 >> k)) $display("FAIL lanes_latency[L=%0d]: got %0d, want %0d", 1 << k, lat, 4 >> k);
         else pass_cnt++;
         check_cnt++;
         if (busy_ok !== 1'b1 || done_ok !== 1'b1)
            $display("FAIL lanes_handshake[L=%0d]: got busy_ok=%b done_ok=%b, want 1 1", 1 << k, busy_ok, done_ok);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      int k, lat;
      logic [127:0] a, b, exp_a, exp_b;
      k = 1;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      exp_a = ref_state(a, 1'b1);
      exp_b = ref_state(b, 1'b1);
      @(negedge clk);
      in_valid[k] = 1'b1;
      in_data[k]  = a;
      @(negedge clk);
      in_valid[k] = 1'b0;
      lat = 0;
      while (out_valid[k] !== 1'b1 && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
      check_cnt++;
      if (lat !== 2) $display("FAIL bp_latency_a: got %0d, want 2", lat);
      else pass_cnt++;
      in_valid[k] = 1'b1;
      in_data[k]  = b;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_cnt++;
         if (out_valid[k] !== 1'b1 || out_data[k] !== exp_a || in_ready[k] !== 1'b0)
            $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b out_data=%h, want 1 0 %h",
                     c, out_valid[k], in_ready[k], out_data[k], exp_a);
         else pass_cnt++;
      end
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
      check_cnt++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1)
         $display("FAIL bp_release: got out_valid=%b in_ready=%b, want 0 1", out_valid[k], in_ready[k]);
      else pass_cnt++;
      @(negedge clk);
      in_valid[k] = 1'b0;
      check_cnt++;
      if (in_ready[k] !== 1'b0)
         $display("FAIL bp_accept_next: got in_ready=%b, want 0", in_ready[k]);
      else pass_cnt++;
      lat = 0;
      while (out_valid[k] !== 1'b1 && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
      check_cnt++;
      if (lat !== 2 || out_data[k] !== exp_b)
         $display("FAIL bp_second: got lat=%0d data=%h, want 2 %h", lat, out_data[k], exp_b);
      else pass_cnt++;
      out_ready[k] = 1'b1;
      @(negedge clk);
      out_ready[k] = 1'b0;
   endtask

   task automatic test_exhaustive();
      logic [127:0] data, exp, res;
      int lat;
      bit busy_ok, done_ok;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            data[8*j +: 8] = ref_sbox[16*i + j];
            exp[8*j +: 8]  = 8'(16*i + j);
         end
         for (int k = 0; k < NDUT; k++) begin
            do_txn(k, data, 1'b1, res, lat, busy_ok, done_ok);
            check_cnt++;
            if (res !== exp || lat !== (4 >> k))
               $display("FAIL exhaustive[%0d][L=%0d]: got lat=%0d data=%h, want %0d %h",
                        i, 1 << k, lat, res, 4 >> k, exp);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] d [3];
      logic [127:0] got [3];
      int acc_t [3];
      int n_acc, n_out, cyc;
      bit pend;
      for (int k = 0; k < NDUT; k++) begin
         for (int i = 0; i < 3; i++) begin
            d[i]     = {$urandom, $urandom, $urandom, $urandom};
            got[i]   = '0;
            acc_t[i] = -100;
         end
         n_acc = 0;
         n_out = 0;
         cyc   = 0;
         pend  = 1'b0;
         @(negedge clk);
         in_valid[k]  = 1'b1;
         in_data[k]   = d[0];
         out_ready[k] = 1'b1;
         while (n_out < 3 && cyc < 60) begin
            if (out_valid[k] === 1'b1) begin
               got[n_out] = out_data[k];
               n_out++;
            end
            if (in_ready[k] === 1'b1 && in_valid[k] === 1'b1 && n_acc < 3) begin
               acc_t[n_acc] = cyc;
               n_acc++;
               pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
               pend = 1'b0;
               if (n_acc < 3) in_data[k] = d[n_acc];
               else in_valid[k] = 1'b0;
            end
         end
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         for (int i = 1; i < 3; i++) begin
            check_cnt++;
            if (acc_t[i] - acc_t[i-1] !== (4 >> k) + 2)
               $display("FAIL b2b_period[L=%0d][%0d]: got %0d, want %0d",
                        1 << k, i, acc_t[i] - acc_t[i-1], (4 >> k) + 2);
            else pass_cnt++;
         end
         for (int i = 0; i < 3; i++) begin
            check_cnt++;
            if (got[i] !== ref_state(d[i], 1'b1))
               $display("FAIL b2b_data[L=%0d][%0d]: got %h, want %h", 1 << k, i, got[i], ref_state(d[i], 1'b1));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] data, res, exp;
      logic md;
      int k, lat;
      bit busy_ok, done_ok;
      for (int n = 0; n < 24; n++) begin
         k    = $urandom_range(0, NDUT - 1);
         data = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_SUB_MODE_EN
         md      = 1'($urandom_range(0, 1));
         mode[k] = md;
`else
         md      = 1'b1;
`endif
         exp = ref_state(data, md);
         do_txn(k, data, 1'b1, res, lat, busy_ok, done_ok);
`ifdef INV_SUB_MODE_EN
         mode[k] = 1'b1;
`endif
         check_cnt++;
         if (res !== exp || busy_ok !== 1'b1 || done_ok !== 1'b1)
            $display("FAIL random[%0d][L=%0d]: got data=%h busy_ok=%b done_ok=%b, want %h 1 1",
                     n, 1 << k, res, busy_ok, done_ok, exp);
         else pass_cnt++;
      end
   endtask

`ifdef INV_SUB_MODE_EN
   task automatic test_mode();
      logic [127:0] fwd_res, inv_res;
      int lat;
      bit busy_ok, done_ok;
      mode[0] = 1'b0;
      do_txn(0, 128'h0, 1'b0, fwd_res, lat, busy_ok, done_ok);
      check_cnt++;
      if (fwd_res !== {16{8'h63}})
         $display("FAIL mode_forward: got %h, want %h", fwd_res, {16{8'h63}});
      else pass_cnt++;
      mode[0] = 1'b1;
      do_txn(0, fwd_res, 1'b0, inv_res, lat, busy_ok, done_ok);
      check_cnt++;
      if (inv_res !== 128'h0)
         $display("FAIL mode_inverse: got %h, want %h", inv_res, 128'h0);
      else pass_cnt++;
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      for (int k = 0; k < NDUT; k++) in_data[k] = '0;
`ifdef INV_SUB_MODE_EN
      mode      = '1;
`endif
      build_ref();
      test_reset();
      test_known_vector();
      test_lanes();
      test_backpressure();
      test_exhaustive();
      test_back_to_back();
      test_random();
`ifdef INV_SUB_MODE_EN
      test_mode();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
